// File: rtl/apb_protocol_checker.sv
// Passive APB4 completer-port monitor with sticky/pulse/code error reporting; APB_CHK_SLVERR_CNT_EN adds slverr_cnt.
// Outputs are registered and valid right after the sampled edge; purely observational, never stalls the bus.
module apb_protocol_checker #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16,
    parameter logic [6:0]  CHECK_MASK = 7'h7F
) (
    input  logic                    clk,
    input  logic                    preset_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic                    pready,
    input  logic                    pslverr,
    input  logic                    err_clr,
    output logic [6:0]              err_sticky,
    output logic                    err_pulse,
    output logic [2:0]              err_code,
    output logic                    txn_done,
    output logic [7:0]              wait_max
`ifdef APB_CHK_SLVERR_CNT_EN
    ,
    output logic [15:0]             slverr_cnt
`endif
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    localparam int B_SEQ        = 0;
    localparam int B_PEN_NO_SEL = 1;
    localparam int B_UNSTABLE   = 2;
    localparam int B_PEN_NOT_DR = 3;
    localparam int B_TIMEOUT    = 4;
    localparam int B_STRB_RD    = 5;
    localparam int B_ABORT      = 6;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [STRB_WIDTH-1:0] strb;
        logic [DATA_WIDTH-1:0] wdata;
    } ctl_t;

    state_t     state_q, state_d;
    ctl_t       ctl_q;
    logic       done_q;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       to_seen_q, to_seen_d;

    logic       setup, access;
    logic       capture, complete, check_stable, mismatch;
    logic [6:0] raw, detected;
    logic [2:0] code_d;
    logic [7:0] wait_max_d;

    assign setup  = psel & ~penable;
    assign access = psel & penable;

    // Write data only matters once a write has been captured.
    assign mismatch = (paddr != ctl_q.addr) | (pwrite != ctl_q.write) |
                      (pstrb != ctl_q.strb) | (ctl_q.write & (pwdata != ctl_q.wdata));

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        to_seen_d    = to_seen_q;
        capture      = 1'b0;
        complete     = 1'b0;
        check_stable = 1'b0;
        raw          = '0;

        raw[B_PEN_NO_SEL] = penable & ~psel;
        raw[B_STRB_RD]    = access & ~pwrite & (|pstrb);

        case (state_q)
            IDLE: begin
                if (setup) begin
                    capture = 1'b1;
                    state_d = SETUP;
                end else if (access) begin
                    if (done_q) raw[B_PEN_NOT_DR] = 1'b1;
                    else        raw[B_SEQ]        = 1'b1;
                end
            end
            SETUP: begin
                if (access) begin
                    check_stable = 1'b1;
                    wait_cnt_d   = '0;
                    if (pready) complete = 1'b1;
                    else        state_d  = ACCESS;
                end else begin
                    raw[B_SEQ] = 1'b1;
                    if (setup) capture = 1'b1;
                    else       state_d = IDLE;
                end
            end
            ACCESS: begin
                if (access) begin
                    check_stable = 1'b1;
                    wait_cnt_d   = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
                    if (pready) complete = 1'b1;
                end else begin
                    raw[B_ABORT] = 1'b1;
                    if (setup) begin
                        capture = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) state_d = IDLE;
        if (check_stable) raw[B_UNSTABLE] = mismatch;

        // One timeout report per transfer; a new capture re-arms it.
        if (check_stable && (TIMEOUT != 0) && !pready && !to_seen_q &&
            ({24'd0, wait_cnt_d} >= TIMEOUT)) begin
            raw[B_TIMEOUT] = 1'b1;
            to_seen_d      = 1'b1;
        end
        if (capture) to_seen_d = 1'b0;
    end

    assign detected = raw & CHECK_MASK;

    always_comb begin
        code_d = err_code;
        for (int i = 6; i >= 0; i--) begin
            if (detected[i]) code_d = 3'(i);
        end
    end

    always_comb begin
        wait_max_d = err_clr ? 8'd0 : wait_max;
        if (complete && (wait_cnt_d > wait_max_d)) wait_max_d = wait_cnt_d;
    end

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            state_q    <= IDLE;
            ctl_q      <= '0;
            done_q     <= 1'b0;
            wait_cnt_q <= '0;
            to_seen_q  <= 1'b0;
            err_sticky <= '0;
            err_pulse  <= 1'b0;
            err_code   <= '0;
            txn_done   <= 1'b0;
            wait_max   <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= complete;
            wait_cnt_q <= wait_cnt_d;
            to_seen_q  <= to_seen_d;
            if (capture) begin
                ctl_q.addr  <= paddr;
                ctl_q.write <= pwrite;
                ctl_q.strb  <= pstrb;
                if (pwrite) ctl_q.wdata <= pwdata;
            end
            err_sticky <= (err_clr ? 7'd0 : err_sticky) | detected;
            err_pulse  <= |detected;
            err_code   <= code_d;
            txn_done   <= complete;
            wait_max   <= wait_max_d;
        end
    end

`ifdef APB_CHK_SLVERR_CNT_EN
    logic [15:0] slverr_cnt_d;

    always_comb begin
        slverr_cnt_d = err_clr ? 16'd0 : slverr_cnt;
        if (complete && pslverr && (slverr_cnt_d != 16'hFFFF)) slverr_cnt_d = slverr_cnt_d + 16'd1;
    end

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) slverr_cnt <= '0;
        else           slverr_cnt <= slverr_cnt_d;
    end
`else
    logic unused_pslverr;
    assign unused_pslverr = pslverr;
`endif

endmodule
